instr_fetch_queue: RTL



---
 rtl/ifq_pkg.sv | 18 +
 rtl/ifq_fifo.sv | 53 +++++
 rtl/instr_fetch_queue.sv | 124 ++++++++++++
 3 files changed

// File: rtl/ifq_pkg.sv
// rtl/ifq_pkg.sv - shared widths, queue entry type and fetch FSM states
package ifq_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 16;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } ifq_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } ifq_state_t;

endpackage

// File: rtl/ifq_fifo.sv
// rtl/ifq_fifo.sv - circular buffer of fetched {pc, instr} pairs with flush
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  ifq_entry_t                 push_data,
    input  logic                       pop,
    input  logic                       flush,
    output ifq_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    ifq_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head      = mem[rd_ptr];
    assign occupancy = count;

endmodule

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - decoupled fetch front end: PC, imem handshake, queue, redirect
// Optional zero-latency bypass of the empty queue when IFQ_BYPASS_EN is defined.
module instr_fetch_queue
    import ifq_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic                       clk,
    input  logic                       Clear_n,
    output logic                       imem_req,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic                       imem_ack,
    input  logic [INSTR_W-1:0]         imem_rdata,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic                       out_valid,
    output logic [INSTR_W-1:0]         out_instr,
    output logic [ADDR_W-1:0]          out_pc,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int CNT_W = $clog2(DEPTH+1);

    ifq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    ifq_entry_t        head;
    logic              fifo_valid;
    logic              fifo_push;
    logic              fifo_pop;
    logic              bypass;
    logic [CNT_W-1:0]  occ_post;
    logic              space;

    assign fifo_valid = (occupancy != '0);

`ifdef IFQ_BYPASS_EN
    assign bypass    = (occupancy == '0) && (state_q == WAIT) && imem_ack && !redirect;
    assign out_valid = fifo_valid | bypass;
    assign out_instr = bypass ? imem_rdata : head.instr;
    assign out_pc    = bypass ? addr_q : head.pc;
`else
    assign bypass    = 1'b0;
    assign out_valid = fifo_valid;
    assign out_instr = head.instr;
    assign out_pc    = head.pc;
`endif

    // A bypassed word that the core takes this cycle never enters storage.
    assign fifo_pop  = fifo_valid && out_ready && !redirect;
    assign fifo_push = (state_q == WAIT) && imem_ack && !redirect && !(bypass && out_ready);
    assign occ_post  = occupancy + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    assign space     = (occ_post < CNT_W'(DEPTH));

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                end else if (space) begin
                    state_d    = WAIT;
                    addr_d     = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 16'd1;
                end
            end
            WAIT: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                    state_d    = imem_ack ? IDLE : DROP;
                end else if (imem_ack) begin
                    if (space) begin
                        addr_d     = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + 16'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                end
                if (imem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge Clear_n) begin
        if (!Clear_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
        end
    end

    assign imem_req  = (state_q != IDLE);
    assign imem_addr = addr_q;

    ifq_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (Clear_n),
        .push     (fifo_push),
        .push_data('{pc: addr_q, instr: imem_rdata}),
        .pop      (fifo_pop),
        .flush    (redirect),
        .head     (head),
        .occupancy(occupancy)
    );

endmodule
